vending_machine_param: RTL
==========================

// Module: vending_machine_param
// PURPOSE
//  Parametrised ticket vending controller: accepts up to three coin denominations, sells one
//  ticket at a programmable price, returns change, and supports cancel/refund and stock
//  tracking with sold-out lockout and restock. Successor to the fixed-price vending_machine.
// PARAMETERS
//  PRICE     15  ticket price in credit units (>0)
//  COIN_A     5  value of coin code 2'b01
//  COIN_B    10  value of coin code 2'b10
//  COIN_C    25  value of coin code 2'b11
//  CREDIT_W   8  credit/change width; must hold PRICE-1+max(COIN_*) (elaboration check)
//  STOCK      8  tickets loaded at reset/restock (>0)
//  STOCK_W    4  stock counter width; must hold STOCK
// PORTS
//  clk         in   1         clock, rising edge
//  rst         in   1         synchronous reset, active high
//  coin        in   2         insertion code this cycle: 00 none, 01 A, 10 B, 11 C
//  cancel      in   1         request refund of current credit
//  restock     in   1         reload stock to STOCK
//  ticket      out  1         one-cycle pulse: ticket dispensed
//  change      out  CREDIT_W  change amount; valid only when change_valid=1, else 0
//  change_valid out 1         one-cycle pulse: pay out change
//  credit      out  CREDIT_W  accumulated credit (registered)
//  sold_out    out  1         stock is zero
//  coin_reject out  1         combinational: coin!=00 this cycle and not accepted
// BEHAVIOUR
//  - Each cycle with coin!=00 is one insertion; a code held N cycles counts N coins.
//  - Reset (any state, including mid-VEND/REFUND): state IDLE, credit=0, stock=STOCK; credit
//    in progress is lost. ticket, change, change_valid are 0 in the cycle after the reset edge.
//  - ticket/change/change_valid are decoded from registered state: Moore, latency 1 cycle
//    after the edge that accepts the final coin or the cancel.
//  - States:
//    IDLE: credit==0. Coin accepted: sum=value; sum>=PRICE -> VEND, else COLLECT.
//          cancel ignored. restock reloads stock.
//    COLLECT: coin accepted: sum=credit+value; sum>=PRICE -> VEND, else stay.
//          cancel -> REFUND. cancel+coin in the same cycle: cancel wins, coin rejected.
//    VEND (1 cycle): ticket=1, change=credit-PRICE, change_valid=(change!=0).
//          At exit edge: credit<=0, stock<=stock-1; stock becomes 0 -> SOLDOUT, else IDLE.
//    REFUND (1 cycle): change=credit, change_valid=1, ticket=0. At exit edge: credit<=0 -> IDLE.
//    SOLDOUT: sold_out=1; all coins rejected; cancel ignored;
//          restock -> stock<=STOCK, state IDLE.
//  - In VEND entry, credit register holds sum (credit+value); no wrap (width check guarantees).
//  - Coins in VEND, REFUND, SOLDOUT are rejected: coin_reject=1, no credit change.
//  - restock outside IDLE/SOLDOUT is ignored.
//  - sold_out = (stock==0). Registered; equals 0 out of reset.
// TESTING (defaults PRICE=15, A/B/C=5/10/25)
//  1 rst high 2 cycles -> ticket=0, change_valid=0, credit=0, sold_out=0, state IDLE.
//  2 coin 01,01,01 on 3 consecutive cycles -> credit 5 then 10; next cycle ticket=1,
//    change_valid=0; then credit=0.
//  3 coin 11 from IDLE -> next cycle ticket=1, change=10, change_valid=1; then IDLE, credit=0.
//  4 coin 10, then cancel=1 with coin=01 -> coin_reject=1; next cycle change=10,
//    change_valid=1, ticket=0.
//  5 STOCK=2: two 15-credit sales -> sold_out=1; coin 10 -> coin_reject=1, credit=0;
//    restock -> sold_out=0, IDLE.
//  6 coin 11 then coin 01 during VEND cycle -> coin_reject=1, credit=0 after VEND;
//    rst asserted in COLLECT (credit=10) -> credit=0, no ticket/change.

Source files
------------

// File: rtl/vending_machine_param_if.sv
// ----------------------------------------------------------------------------
// vending_machine_param_if
//   Bundles the user-facing signals of the ticket vending controller.
//   master : customer/panel side (drives coin, cancel, restock)
//   slave  : controller side (drives ticket, change, change_valid, credit,
//            sold_out, coin_reject)
// Parameters
//   CREDIT_W : width of the credit and change buses
// ----------------------------------------------------------------------------
interface vending_machine_param_if #(
    parameter int CREDIT_W = 8
);
    logic [1:0]          coin;
    logic                cancel;
    logic                restock;
    logic                ticket;
    logic [CREDIT_W-1:0] change;
    logic                change_valid;
    logic [CREDIT_W-1:0] credit;
    logic                sold_out;
    logic                coin_reject;

    modport master (
        output coin, cancel, restock,
        input  ticket, change, change_valid, credit, sold_out, coin_reject
    );

    modport slave (
        input  coin, cancel, restock,
        output ticket, change, change_valid, credit, sold_out, coin_reject
    );
endinterface

// File: rtl/vending_machine_param.sv
// ----------------------------------------------------------------------------
// vending_machine_param
//   Parametrised ticket vending controller. Accepts three coin denominations,
//   sells one ticket at PRICE, pays out change, supports cancel/refund, and
//   tracks stock with a sold-out lockout that is cleared by restock.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : vending_machine_param_if.slave
//            coin[1:0]    in  00 none, 01 COIN_A, 10 COIN_B, 11 COIN_C
//            cancel       in  refund current credit
//            restock      in  reload stock to STOCK
//            ticket       out one-cycle pulse, ticket dispensed
//            change       out change amount, 0 unless change_valid
//            change_valid out one-cycle pulse, pay out change
//            credit       out accumulated credit (registered)
//            sold_out     out stock is zero (registered)
//            coin_reject  out combinational, coin presented but not accepted
// ----------------------------------------------------------------------------
module vending_machine_param #(
    parameter int PRICE    = 15,
    parameter int COIN_A   = 5,
    parameter int COIN_B   = 10,
    parameter int COIN_C   = 25,
    parameter int CREDIT_W = 8,
    parameter int STOCK    = 8,
    parameter int STOCK_W  = 4
) (
    input logic                     clk,
    input logic                     rst,
    vending_machine_param_if.slave  bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COLLECT = 3'd1;
    localparam logic [2:0] VEND    = 3'd2;
    localparam logic [2:0] REFUND  = 3'd3;
    localparam logic [2:0] SOLDOUT = 3'd4;

    localparam int MAX_AB   = (COIN_A > COIN_B) ? COIN_A : COIN_B;
    localparam int MAX_COIN = (MAX_AB > COIN_C) ? MAX_AB : COIN_C;

    // The largest credit ever held is one coin short of the price plus the
    // biggest coin; the credit register must hold it without wrapping.
    if (PRICE <= 0) begin : g_bad_price
        $error("PRICE must be greater than zero");
    end
    if (PRICE - 1 + MAX_COIN > (1 << CREDIT_W) - 1) begin : g_bad_credit_w
        $error("CREDIT_W too narrow for PRICE-1+max coin value");
    end
    if (STOCK <= 0 || STOCK > (1 << STOCK_W) - 1) begin : g_bad_stock
        $error("STOCK must be >0 and fit in STOCK_W bits");
    end

    localparam logic [CREDIT_W-1:0] PRICE_V  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] COIN_A_V = CREDIT_W'(COIN_A);
    localparam logic [CREDIT_W-1:0] COIN_B_V = CREDIT_W'(COIN_B);
    localparam logic [CREDIT_W-1:0] COIN_C_V = CREDIT_W'(COIN_C);
    localparam logic [STOCK_W-1:0]  STOCK_V  = STOCK_W'(STOCK);

    logic [2:0]          state, state_d;
    logic [CREDIT_W-1:0] credit, credit_d;
    logic [STOCK_W-1:0]  stock, stock_d;
    logic                sold_out;
    logic                accept;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] sum;
    logic [CREDIT_W-1:0] change_amt;

    always_comb begin
        unique case (bus.coin)
            2'b01:   coin_val = COIN_A_V;
            2'b10:   coin_val = COIN_B_V;
            2'b11:   coin_val = COIN_C_V;
            default: coin_val = '0;
        endcase
    end

    // Credit is zero in IDLE, so one adder covers both IDLE and COLLECT.
    assign sum = credit + coin_val;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state;
        credit_d = credit;
        stock_d  = stock;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.coin != 2'b00) begin
                    accept   = 1'b1;
                    credit_d = sum;
                    state_d  = (sum >= PRICE_V) ? VEND : COLLECT;
                end
                if (bus.restock) stock_d = STOCK_V;
            end
            COLLECT: begin
                // Cancel has priority; a coin in the same cycle is rejected.
                if (bus.cancel) begin
                    state_d = REFUND;
                end else if (bus.coin != 2'b00) begin
                    accept   = 1'b1;
                    credit_d = sum;
                    if (sum >= PRICE_V) state_d = VEND;
                end
            end
            VEND: begin
                credit_d = '0;
                stock_d  = stock - 1'b1;
                state_d  = (stock_d == '0) ? SOLDOUT : IDLE;
            end
            REFUND: begin
                credit_d = '0;
                state_d  = IDLE;
            end
            SOLDOUT: begin
                if (bus.restock) begin
                    stock_d = STOCK_V;
                    state_d = IDLE;
                end
            end
            default: begin
                credit_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            credit   <= '0;
            stock    <= STOCK_V;
            sold_out <= 1'b0;
        end else begin
            state    <= state_d;
            credit   <= credit_d;
            stock    <= stock_d;
            sold_out <= (stock_d == '0);
        end
    end

    // Moore outputs decoded from the registered state and credit.
    always_comb begin
        change_amt = '0;
        if (state == VEND)        change_amt = credit - PRICE_V;
        else if (state == REFUND) change_amt = credit;
    end

    assign bus.ticket       = (state == VEND);
    assign bus.change       = change_amt;
    assign bus.change_valid = ((state == VEND) && (change_amt != '0)) || (state == REFUND);
    assign bus.credit       = credit;
    assign bus.sold_out     = sold_out;
    assign bus.coin_reject  = (bus.coin != 2'b00) && !accept;

endmodule
